imem_loader: RTL and testbench

- Write-side counterpart of the instruction fetch path. It receives a byte stream over a valid/ready handshake and assembles little-endian 32-bit words.
- Each assembled word is written into instruction memory at consecutive word addresses.
- The processor core is held in reset (core_reset) until a complete, checksum-verified image has been loaded.
- Sits between an external byte source (UART/debug bridge) and the imem write port.

---
 rtl/imem_loader_pkg.sv | 23 ++
 rtl/imem_loader_if.sv | 25 ++
 rtl/imem_loader_byte_packer.sv | 40 ++++
 rtl/imem_loader.sv | 111 +++++++++++
 tb/tb_imem_loader.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// The header length and word size also set the minimum load time of an image.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        HDR0,
        HDR1,
        DATA,
        WR,
        CHK,
        DONE,
        ERR
    } state_e;

    localparam int HDR_BYTES  = 2;
    localparam int WORD_BYTES = 4;

    // Clock edges from the first header byte to the checksum byte, with no source gaps.
    function automatic int minLoadCycles(input int nWords);
        return HDR_BYTES + (WORD_BYTES + 1) * nWords + 1;
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream handshake, imem write port and status lines of the loader.
// The byte source drives master; the loader is the slave.
interface imem_loader_if;

    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        imem_we;
    logic [31:0] imem_waddr;
    logic [31:0] imem_wdata;
    logic        core_reset;
    logic        done;
    logic        error;

    modport master (
        output byte_valid, byte_data,
        input  byte_ready, imem_we, imem_waddr, imem_wdata, core_reset, done, error
    );

    modport slave (
        input  byte_valid, byte_data,
        output byte_ready, imem_we, imem_waddr, imem_wdata, core_reset, done, error
    );

endinterface

// File: rtl/imem_loader_byte_packer.sv
// Assembles four accepted bytes into a little-endian word, lane 0 first.
// word_o already includes the byte being pushed, so the word is complete on the 4th push.
module imem_loader_byte_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear_i,
    input  logic        push_i,
    input  logic [7:0]  data_i,
    output logic        word_full_o,
    output logic [31:0] word_o
);

    logic [1:0]  lane_q;
    logic [31:0] word_q;
    logic [31:0] word_d;

    always_comb begin
        word_d = word_q;
        if (push_i) begin
            word_d[{lane_q, 3'b000} +: 8] = data_i;
        end
    end

    assign word_o      = word_d;
    assign word_full_o = push_i && (lane_q == 2'd3);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lane_q <= '0;
            word_q <= '0;
        end else if (clear_i) begin
            lane_q <= '0;
            word_q <= '0;
        end else if (push_i) begin
            lane_q <= lane_q + 2'd1;
            word_q <= word_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Loads a counted, XOR-checksummed byte image into instruction memory and
// releases the core from reset only once the whole image has verified.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int          DEPTH     = 64,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         reset,
    imem_loader_if.slave bus
);

    localparam int WIDX_W = $clog2(DEPTH + 1);

    state_e            state_q, state_d;
    logic              byteReady_q, imemWe_q, coreReset_q, done_q, error_q;
    logic [31:0]       imemWaddr_q, imemWdata_q;
    logic [15:0]       wordCount_q;
    logic [WIDX_W-1:0] wordIdx_q, wordIdxNext;
    logic [7:0]        checksum_q;
    logic              accept, dataPush, packerClear, wordFull;
    logic [31:0]       packedWord;
    logic [15:0]       headerCount;

    assign accept      = bus.byte_valid && byteReady_q;
    assign dataPush    = (state_q == DATA) && accept;
    assign packerClear = (state_q == HDR1) && accept;
    assign headerCount = {bus.byte_data, wordCount_q[7:0]};
    assign wordIdxNext = wordIdx_q + WIDX_W'(1);

    imem_loader_byte_packer u_packer (
        .clk         (clk),
        .reset       (reset),
        .clear_i     (packerClear),
        .push_i      (dataPush),
        .data_i      (bus.byte_data),
        .word_full_o (wordFull),
        .word_o      (packedWord)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            HDR0: if (accept) state_d = HDR1;
            HDR1: begin
                if (accept) begin
                    if (headerCount > 16'(DEPTH))    state_d = ERR;
                    else if (headerCount == 16'd0)   state_d = CHK;
                    else                             state_d = DATA;
                end
            end
            DATA: if (wordFull) state_d = WR;
            WR:   state_d = (16'(wordIdxNext) == wordCount_q) ? CHK : DATA;
            CHK:  if (accept) state_d = (bus.byte_data == checksum_q) ? DONE : ERR;
            default: state_d = state_q;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= HDR0;
            byteReady_q <= 1'b0;
            imemWe_q    <= 1'b0;
            imemWaddr_q <= BASE_ADDR;
            imemWdata_q <= '0;
            coreReset_q <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            wordCount_q <= '0;
            wordIdx_q   <= '0;
            checksum_q  <= '0;
        end else begin
            state_q     <= state_d;
            byteReady_q <= (state_d == HDR0) || (state_d == HDR1) ||
                           (state_d == DATA) || (state_d == CHK);
            imemWe_q    <= (state_d == WR);
            coreReset_q <= (state_d != DONE);
            done_q      <= (state_d == DONE);
            error_q     <= (state_d == ERR);
            if ((state_q == HDR0) && accept) begin
                wordCount_q[7:0] <= bus.byte_data;
            end
            if (packerClear) begin
                wordCount_q <= headerCount;
                wordIdx_q   <= '0;
                checksum_q  <= '0;
            end
            if (dataPush) begin
                checksum_q <= checksum_q ^ bus.byte_data;
            end
            if (wordFull) begin
                imemWdata_q <= packedWord;
                imemWaddr_q <= BASE_ADDR + 32'(wordIdx_q) * 32'(WORD_BYTES);
            end
            if (state_q == WR) begin
                wordIdx_q <= wordIdxNext;
            end
        end
    end

    assign bus.byte_ready = byteReady_q;
    assign bus.imem_we    = imemWe_q;
    assign bus.imem_waddr = imemWaddr_q;
    assign bus.imem_wdata = imemWdata_q;
    assign bus.core_reset = coreReset_q;
    assign bus.done       = done_q;
    assign bus.error      = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: expected writes are queued as bytes are driven
// and popped by a monitor whenever the write strobe is seen.
module tb_imem_loader;
    import imem_loader_pkg::*;

    localparam int          DEPTH = 64;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    imem_loader_if bus ();

    imem_loader #(
        .DEPTH     (DEPTH),
        .BASE_ADDR (BASE)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          checks     = 0;
    int          errors     = 0;
    int          cycle      = 0;
    int          writeCount = 0;
    int          lastAccept = 0;
    int          hdrCycle   = 0;
    logic [31:0] lastAddr   = '0;
    logic [31:0] expAddrQ[$];
    logic [31:0] expDataQ[$];
    logic [31:0] img[DEPTH];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Write monitor: every strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        cycle++;
        if (bus.imem_we === 1'b1) begin
            writeCount++;
            lastAddr = bus.imem_waddr;
            checkOutput("readyLowInWr", 32'(bus.byte_ready), 32'd0);
            checkOutput("writeExpected", 32'(expAddrQ.size() > 0), 32'd1);
            if (expAddrQ.size() > 0) begin
                checkOutput("waddr", bus.imem_waddr, expAddrQ.pop_front());
                checkOutput("wdata", bus.imem_wdata, expDataQ.pop_front());
            end
        end
    end

    task automatic applyStimulus(input logic [7:0] b, input int gap);
        int waitCycles;
        waitCycles = 0;
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        forever begin
            @(negedge clk);
            if (bus.byte_ready === 1'b1) break;
            waitCycles++;
            if (waitCycles > 200) break;
        end
        checkOutput("handshakeBound", 32'(waitCycles <= 200), 32'd1);
        if (waitCycles <= 200) begin
            @(posedge clk);
            lastAccept = cycle;
            #1;
        end
        bus.byte_valid = 1'b0;
        repeat (gap) @(posedge clk);
        #1;
    endtask

    task automatic loadImage(input int n, input int gap, input bit useOverride, input logic [7:0] overrideSum);
        logic [7:0]  sum;
        logic [31:0] w;
        logic [15:0] hdr;
        sum = 8'h00;
        hdr = 16'(n);
        applyStimulus(hdr[7:0], gap);
        hdrCycle = lastAccept;
        applyStimulus(hdr[15:8], gap);
        for (int i = 0; i < n; i++) begin
            w = img[i];
            expAddrQ.push_back(BASE + 32'(i) * 32'd4);
            expDataQ.push_back(w);
            for (int k = 0; k < 4; k++) begin
                applyStimulus(w[8*k +: 8], gap);
                sum = sum ^ w[8*k +: 8];
            end
        end
        applyStimulus(useOverride ? overrideSum : sum, gap);
    endtask

    task automatic checkResetValues(input string prefix);
        checkOutput({prefix, "_ready"},     32'(bus.byte_ready), 32'd0);
        checkOutput({prefix, "_we"},        32'(bus.imem_we),    32'd0);
        checkOutput({prefix, "_waddr"},     bus.imem_waddr,      BASE);
        checkOutput({prefix, "_wdata"},     bus.imem_wdata,      32'd0);
        checkOutput({prefix, "_coreReset"}, 32'(bus.core_reset), 32'd1);
        checkOutput({prefix, "_done"},      32'(bus.done),       32'd0);
        checkOutput({prefix, "_error"},     32'(bus.error),      32'd0);
    endtask

    task automatic doReset();
        reset = 1'b1;
        expAddrQ.delete();
        expDataQ.delete();
        repeat (2) @(posedge clk);
        #1;
        writeCount = 0;
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic setBasicImage();
        img[0] = 32'h00A0_0513;
        img[1] = 32'h00B5_05B3;
    endtask

    task automatic checkDone(input string prefix, input int writes);
        checkOutput({prefix, "_done"},      32'(bus.done),       32'd1);
        checkOutput({prefix, "_coreReset"}, 32'(bus.core_reset), 32'd0);
        checkOutput({prefix, "_error"},     32'(bus.error),      32'd0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput({prefix, "_readyAfter"}, 32'(bus.byte_ready),  32'd0);
        checkOutput({prefix, "_writes"},     32'(writeCount),       32'(writes));
        checkOutput({prefix, "_sbEmpty"},    32'(expAddrQ.size()),  32'd0);
    endtask

    initial begin
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;

        #12;
        checkResetValues("rst");
        @(posedge clk);
        #1;
        reset = 1'b0;
        checkOutput("readyBeforeEdge", 32'(bus.byte_ready), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("readyAfterEdge", 32'(bus.byte_ready), 32'd1);

        $display("[TB] basic load");
        setBasicImage();
        loadImage(2, 0, 1'b0, 8'h00);
        checkOutput("basic_latency", 32'(lastAccept - hdrCycle), 32'(minLoadCycles(2) - 1));
        checkDone("basic", 2);

        $display("[TB] load with source gaps");
        doReset();
        loadImage(2, 3, 1'b0, 8'h00);
        checkDone("gaps", 2);

        $display("[TB] bad checksum");
        doReset();
        loadImage(2, 0, 1'b1, 8'hFF);
        checkOutput("badSum_error",     32'(bus.error),      32'd1);
        checkOutput("badSum_done",      32'(bus.done),       32'd0);
        checkOutput("badSum_coreReset", 32'(bus.core_reset), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("badSum_ready",  32'(bus.byte_ready), 32'd0);
        checkOutput("badSum_writes", 32'(writeCount),     32'd2);

        $display("[TB] empty image");
        doReset();
        loadImage(0, 0, 1'b0, 8'h00);
        checkDone("empty", 0);

        $display("[TB] full-depth image");
        doReset();
        for (int i = 0; i < DEPTH; i++) img[i] = $urandom;
        loadImage(DEPTH, 0, 1'b0, 8'h00);
        checkDone("full", DEPTH);
        checkOutput("full_lastAddr", lastAddr, BASE + 32'h0000_00FC);

        $display("[TB] oversize header");
        doReset();
        applyStimulus(8'h41, 0);
        applyStimulus(8'h00, 0);
        checkOutput("oversize_error", 32'(bus.error), 32'd1);
        checkOutput("oversize_done",  32'(bus.done),  32'd0);
        repeat (5) @(posedge clk);
        #1;
        checkOutput("oversize_writes", 32'(writeCount),     32'd0);
        checkOutput("oversize_ready",  32'(bus.byte_ready), 32'd0);

        $display("[TB] reset during load");
        doReset();
        setBasicImage();
        applyStimulus(8'h02, 0);
        applyStimulus(8'h00, 0);
        for (int k = 0; k < 4; k++) applyStimulus(img[0][8*k +: 8], 0);
        checkOutput("midReset_weBefore", 32'(bus.imem_we), 32'd1);
        reset = 1'b1;
        #1;
        checkResetValues("midReset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("midReset_writesLost", 32'(writeCount), 32'd0);
        loadImage(2, 0, 1'b0, 8'h00);
        checkDone("replay", 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        $display("[TB] FAIL globalTimeout: observed=running expected=finished");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "[TB] global timeout");
    end

endmodule
